// File: rtl/vec_accel_pkg.sv
// Shared definitions for the vector reduction accelerator: op codes,
// scheduler state encoding and watchdog slack.
package vec_accel_pkg;

    localparam logic [1:0] OP_SUM = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_MIN = 2'b10;
    localparam logic [1:0] OP_MAX = 2'b11;

    // Cycles beyond N the ALU is allowed before the watchdog fires
    localparam int unsigned WDOG_SLACK = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } sched_state_t;

endpackage

// File: rtl/reduce_vector_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first valid request scanning upward
// from ptr with wrap-around, returned one-hot and encoded.
module rr_arbiter #(
    parameter int unsigned REQS = 4,
    localparam int unsigned IDW = $clog2(REQS)
) (
    input  logic [REQS-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [REQS-1:0] gnt_c,
    output logic [IDW-1:0]  gnt_id_c,
    output logic            found_c
);

    int unsigned    idx;
    logic [IDW-1:0] idx_w;

    always_comb begin
        gnt_c    = '0;
        gnt_id_c = '0;
        found_c  = 1'b0;
        idx      = 0;
        idx_w    = '0;
        for (int unsigned i = 0; i < REQS; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= REQS) begin
                idx = idx - REQS;
            end
            idx_w = IDW'(idx);
            if (!found_c && req[idx_w]) begin
                found_c      = 1'b1;
                gnt_c[idx_w] = 1'b1;
                gnt_id_c     = idx_w;
            end
        end
    end

endmodule

// File: rtl/reduce_vector_scheduler.sv
// Round-robin scheduler sharing one reduce_vector_alu between REQS requesters,
// with a watchdog that turns a hung ALU into an error response.
module reduce_vector_scheduler
    import vec_accel_pkg::*;
#(
    parameter int unsigned BITS = 8,
    parameter int unsigned N    = 64,
    parameter int unsigned REQS = 4,
    localparam int unsigned IDW = $clog2(REQS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REQS-1:0]   req_valid,
    input  logic [2*REQS-1:0] req_op,
    output logic [REQS-1:0]   req_ready,
    output logic              alu_set,
    output logic [1:0]        alu_sel,
    output logic              alu_en,
    output logic [IDW-1:0]    alu_src,
    input  logic [BITS-1:0]   alu_out,
    input  logic              alu_done,
    output logic              resp_valid,
    output logic [IDW-1:0]    resp_id,
    output logic [BITS-1:0]   resp_data,
    output logic              resp_err,
    output logic              busy
);

    localparam int unsigned    WDW        = $clog2(N + WDOG_SLACK + 1);
    localparam logic [WDW-1:0] WDOG_LIMIT = WDW'(N + WDOG_SLACK);

    sched_state_t    state, state_d;
    logic [IDW-1:0]  ptr, ptr_d;
    logic [WDW-1:0]  wdog, wdog_d;

    logic [REQS-1:0] req_ready_d;
    logic            alu_set_d;
    logic [1:0]      alu_sel_d;
    logic            alu_en_d;
    logic [IDW-1:0]  alu_src_d;
    logic            resp_valid_d;
    logic [IDW-1:0]  resp_id_d;
    logic [BITS-1:0] resp_data_d;
    logic            resp_err_d;
    logic            busy_d;

    logic [REQS-1:0] arb_gnt;
    logic [IDW-1:0]  arb_id;
    logic            arb_found;

    rr_arbiter #(.REQS(REQS)) u_arb (
        .req      (req_valid),
        .ptr      (ptr),
        .gnt_c    (arb_gnt),
        .gnt_id_c (arb_id),
        .found_c  (arb_found)
    );

    // Outputs are registered from the next-state decode so each one lines up
    // with the state it belongs to (e.g. alu_set is high exactly in ISSUE).
    always_comb begin
        state_d      = state;
        ptr_d        = ptr;
        wdog_d       = wdog;
        req_ready_d  = '0;
        alu_set_d    = 1'b0;
        alu_en_d     = 1'b0;
        alu_sel_d    = alu_sel;
        alu_src_d    = alu_src;
        resp_valid_d = 1'b0;
        resp_id_d    = resp_id;
        resp_data_d  = resp_data;
        resp_err_d   = resp_err;

        case (state)
            S_IDLE: begin
                if (arb_found) begin
                    state_d     = S_ISSUE;
                    alu_src_d   = arb_id;
                    alu_sel_d   = req_op[{arb_id, 1'b0} +: 2];
                    req_ready_d = arb_gnt;
                    alu_set_d   = 1'b1;
                end
            end
            S_ISSUE: begin
                state_d  = S_WAIT;
                wdog_d   = '0;
                alu_en_d = 1'b1;
            end
            S_WAIT: begin
                // done is only trusted here; the previous op leaves it high until set
                if (alu_done) begin
                    state_d      = S_RESP;
                    resp_data_d  = alu_out;
                    resp_err_d   = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_id_d    = alu_src;
                end else if (wdog == WDOG_LIMIT) begin
                    state_d      = S_RESP;
                    resp_data_d  = '0;
                    resp_err_d   = 1'b1;
                    resp_valid_d = 1'b1;
                    resp_id_d    = alu_src;
                end else begin
                    wdog_d   = wdog + WDW'(1);
                    alu_en_d = 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                ptr_d   = (alu_src == IDW'(REQS - 1)) ? '0 : alu_src + IDW'(1);
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            ptr        <= '0;
            wdog       <= '0;
            req_ready  <= '0;
            alu_set    <= 1'b0;
            alu_sel    <= '0;
            alu_en     <= 1'b0;
            alu_src    <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_d;
            ptr        <= ptr_d;
            wdog       <= wdog_d;
            req_ready  <= req_ready_d;
            alu_set    <= alu_set_d;
            alu_sel    <= alu_sel_d;
            alu_en     <= alu_en_d;
            alu_src    <= alu_src_d;
            resp_valid <= resp_valid_d;
            resp_id    <= resp_id_d;
            resp_data  <= resp_data_d;
            resp_err   <= resp_err_d;
            busy       <= busy_d;
        end
    end

endmodule

// File: tb/tb_reduce_vector_scheduler.sv
// Scoreboard bench for reduce_vector_scheduler driving a fake ALU that
// raises done N+1 cycles after set and holds it until the next set.
`timescale 1ns/1ps
module tb_reduce_vector_scheduler;
    import vec_accel_pkg::*;

    localparam int unsigned BITS = 8;
    localparam int unsigned N    = 64;
    localparam int unsigned REQS = 4;
    localparam int unsigned IDW  = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [REQS-1:0]   req_valid = '0;
    logic [2*REQS-1:0] req_op = '0;
    logic [REQS-1:0]   req_ready;
    logic              alu_set;
    logic [1:0]        alu_sel;
    logic              alu_en;
    logic [IDW-1:0]    alu_src;
    logic [BITS-1:0]   alu_out = '0;
    logic              alu_done = 1'b0;
    logic              resp_valid;
    logic [IDW-1:0]    resp_id;
    logic [BITS-1:0]   resp_data;
    logic              resp_err;
    logic              busy;

    typedef struct {
        int              id;
        logic [BITS-1:0] data;
        logic            err;
        int              at;
    } exp_t;

    exp_t            sb[$];
    exp_t            mon_e;
    int              errors = 0;
    int              checks = 0;
    int              cyc = 0;
    int              acnt = 0;
    bit              hang = 1'b0;
    logic [BITS-1:0] alu_tab [REQS];

    reduce_vector_scheduler #(.BITS(BITS), .N(N), .REQS(REQS)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_ready  (req_ready),
        .alu_set    (alu_set),
        .alu_sel    (alu_sel),
        .alu_en     (alu_en),
        .alu_src    (alu_src),
        .alu_out    (alu_out),
        .alu_done   (alu_done),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Fake ALU: done clears on set, rises N+1 cycles later unless hung
    always @(posedge clk) begin
        if (alu_set) begin
            alu_done <= 1'b0;
            acnt     <= 1;
        end else if (acnt != 0) begin
            if (acnt == int'(N)) begin
                acnt <= 0;
                if (!hang) begin
                    alu_done <= 1'b1;
                    alu_out  <= alu_tab[alu_src];
                end
            end else begin
                acnt <= acnt + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] out_vec();
        return 32'({busy, alu_en, alu_set, alu_src, alu_sel, resp_valid,
                    resp_id, resp_data, resp_err, req_ready});
    endfunction

    function automatic void expect_resp(input int id, input logic [BITS-1:0] data,
                                        input logic err, input int at);
        exp_t e;
        e.id   = id;
        e.data = data;
        e.err  = err;
        e.at   = at;
        sb.push_back(e);
    endfunction

    // Response monitor: every pulse must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            if (sb.size() == 0) begin
                check("resp_unexpected", 32'(resp_valid), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("resp_id", 32'(resp_id), 32'(mon_e.id));
                check("resp_data", 32'(resp_data), 32'(mon_e.data));
                check("resp_err", 32'(resp_err), 32'(mon_e.err));
                check("resp_cyc", 32'(cyc), 32'(mon_e.at));
            end
        end
    end

    task automatic wait_ready(input string tag, input logic [REQS-1:0] mask, input int at);
        int n;
        n = 0;
        while (req_ready == '0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, 32'(req_ready), 32'(mask));
        check({tag, "_ready_cyc"}, 32'(cyc), 32'(at));
        check({tag, "_set"}, 32'(alu_set), 32'd1);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drain"}, 32'(sb.size()), 32'd0);
        repeat (2) @(negedge clk);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish by 200us");
        $fatal(1);
    end

    initial begin : main
        int         t0;
        int         id;
        logic [1:0] rr_ops [REQS];

        alu_tab[0] = 8'h3C;
        alu_tab[1] = 8'h7F;
        alu_tab[2] = 8'hFB;   // -5
        alu_tab[3] = 8'h81;
        rr_ops[0]  = OP_SUM;
        rr_ops[1]  = OP_MAX;
        rr_ops[2]  = OP_OR;
        rr_ops[3]  = OP_MIN;

        repeat (2) @(negedge clk);
        check("reset_outputs", out_vec(), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single request from requester 2, op SUM, result -5
        t0 = cyc;
        req_valid = 4'b0100;
        req_op    = '0;
        expect_resp(2, 8'hFB, 1'b0, t0 + 67);
        wait_ready("single", 4'b0100, t0 + 1);
        req_valid = '0;
        @(negedge clk);
        check("single_busy", 32'(busy), 32'd1);
        check("single_en", 32'(alu_en), 32'd1);
        drain("single");

        // Stale done from the previous op stays high through ISSUE
        t0 = cyc;
        req_valid = 4'b0001;
        req_op    = {6'b0, OP_OR};
        expect_resp(0, alu_tab[0], 1'b0, t0 + 67);
        wait_ready("stale", 4'b0001, t0 + 1);
        req_valid = '0;
        drain("stale");

        // Op steering: op changes after accept must not reach the ALU
        t0 = cyc;
        req_valid = 4'b0010;
        req_op    = {4'b0, OP_MAX, 2'b00};
        expect_resp(1, alu_tab[1], 1'b0, t0 + 67);
        wait_ready("steer", 4'b0010, t0 + 1);
        req_valid = '0;
        req_op    = '0;
        for (int k = 0; k < 67; k++) begin
            check("steer_src_sel", 32'({alu_src, alu_sel}), 32'({2'd1, OP_MAX}));
            if (resp_valid) break;
            @(negedge clk);
        end
        drain("steer");

        // Watchdog: ALU never completes
        hang = 1'b1;
        t0 = cyc;
        req_valid = 4'b1000;
        req_op    = {OP_MIN, 6'b0};
        expect_resp(3, 8'h00, 1'b1, t0 + 75);
        wait_ready("wdog", 4'b1000, t0 + 1);
        req_valid = '0;
        drain("wdog");
        hang = 1'b0;

        // Round robin with everyone valid, pointer back at 0 after requester 3
        t0 = cyc;
        req_valid = '1;
        req_op    = {rr_ops[3], rr_ops[2], rr_ops[1], rr_ops[0]};
        for (int k = 0; k < 5; k++) begin
            id = k % int'(REQS);
            expect_resp(id, alu_tab[id], 1'b0, t0 + 67 + 68 * k);
            wait_ready("rr", 4'(1 << id), t0 + 1 + 68 * k);
            check("rr_sel", 32'(alu_sel), 32'(rr_ops[id]));
            if (k == 4) req_valid = '0;
            @(negedge clk);
        end
        drain("rr");

        // Reset in the middle of WAIT drops the op and clears the pointer
        t0 = cyc;
        req_valid = 4'b0100;
        req_op    = {2'b00, OP_MAX, 4'b0};
        wait_ready("mid", 4'b0100, t0 + 1);
        req_valid = '0;
        repeat (30) @(negedge clk);
        check("pre_rst_busy", 32'({busy, alu_en}), 32'b11);
        rst = 1'b1;
        #1;
        check("mid_rst_outputs", out_vec(), 32'd0);
        @(negedge clk);
        check("mid_rst_hold", out_vec(), 32'd0);
        rst = 1'b0;
        t0 = cyc;
        req_valid = '1;
        req_op    = '0;
        expect_resp(0, alu_tab[0], 1'b0, t0 + 67);
        wait_ready("post_rst", 4'b0001, t0 + 1);
        req_valid = '0;
        drain("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
